sht40_measure_ctrl: RTL and testbench
=====================================

# sht40_measure_ctrl

Measurement sequencer for the SHT40 humidity/temperature sensor. It sits above the byte-level I2C master (SCL/SDA engines) and walks that master through a complete transaction: write the measure command, wait out the conversion time, read back the six result bytes, and check the CRC. The raw temperature and humidity words are presented to the rest of the design with a one-cycle valid pulse.

## Interface
- DEV_ADDR, 7'h44, 7-bit I2C address of the sensor.
- MEAS_CMD, 8'hFD, measure command byte (high precision).
- WAIT_CYCLES, 500000, clk cycles between the command STOP and the read START (10 ms at 50 MHz).
- RETRY_CYCLES, 50000, clk cycles to back off after the read address is NACKed.
- MAX_RETRY, 3, number of read-address retries before giving up.

- clk  in  1  system clock; every register updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Meas_Req  in  1  single-cycle request to start one measurement.
- Busy  out  1  high from request acceptance until return to IDLE.
- Data_Valid  out  1  one-cycle pulse when a read sequence completes.
- Crc_Err  out  1  qualified by Data_Valid; 1 means at least one CRC mismatched.
- Nack_Err  out  1  one-cycle pulse when a sequence is aborted on NACK.
- Temp_Raw  out  16  last good temperature word, MSB first.
- Hum_Raw  out  16  last good humidity word, MSB first.
- I2c_Cmd_Valid  out  1  command request to the I2C master.
- I2c_Cmd_Ready  in  1  the master can accept a command.
- I2c_Cmd  out  3  command code:
  - 0: START + write byte
  - 1: write byte
  - 2: read byte, then ACK
  - 3: read byte, then NACK
  - 4: STOP
- I2c_Wr_Data  out  8  byte to send for codes 0 and 1.
- I2c_Done  in  1  one-cycle pulse when the issued command has finished.
- I2c_Nack  in  1  qualified by I2c_Done for codes 0 and 1.
- I2c_Rd_Data  in  8  qualified by I2c_Done for codes 2 and 3.

## Operation
**States and transitions**
- IDLE: Meas_Req=1 moves to W_ADDR, sets Busy, and clears the retry count. Meas_Req is ignored in every other state.
- W_ADDR: issue cmd 0 with data {DEV_ADDR,1'b0} (0x88).
  - Done and NACK: go to ERR_STOP.
  - Done and ACK: go to W_CMD.
- W_CMD: issue cmd 1 with MEAS_CMD.
  - Done and NACK: go to ERR_STOP.
  - Done and ACK: go to W_STOP.
- W_STOP: issue cmd 4. On Done, load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter. At 0, go to R_ADDR.
- R_ADDR: issue cmd 0 with {DEV_ADDR,1'b1} (0x89).
  - Done and ACK: clear the byte index and go to R_BYTE.
  - Done and NACK: go to R_RETRY.
- R_RETRY: issue cmd 4.
  - On Done, if retry count < MAX_RETRY: increment it, load the counter with RETRY_CYCLES-1, and go to WAIT.
  - Otherwise go to ERR_STOP_DONE.
- R_BYTE: issue cmd 2 for byte indices 0–4 and cmd 3 for index 5.
  - Shift each I2c_Rd_Data into a 48-bit buffer.
  - After index 5, go to R_STOP.
- R_STOP: issue cmd 4. On Done, go to CHECK.
- CHECK: one cycle.
  - Buffer layout: T_hi, T_lo, T_crc, H_hi, H_lo, H_crc.
  - Pulse Data_Valid.
  - If both CRCs match, update Temp_Raw and Hum_Raw. On a mismatch, both words keep their previous values.
  - Go to IDLE.
- ERR_STOP: issue cmd 4. On Done, go to ERR_STOP_DONE.
- ERR_STOP_DONE: pulse Nack_Err and go to IDLE.

**Command handshake**
- I2c_Cmd_Valid rises with I2c_Cmd and I2c_Wr_Data stable.
- All three are held until the cycle in which I2c_Cmd_Valid && I2c_Cmd_Ready; Valid drops in the next cycle.
- Only one command is outstanding. The next command is not issued until I2c_Done has been sampled.
- I2c_Done arriving while no command is outstanding is ignored.

**CRC**
- CRC-8, polynomial 0x31, initial value 0xFF, no reflection, no final XOR.
- Computed over each 2-byte word.

**Arithmetic**
- The WAIT counter is $clog2(max(WAIT_CYCLES,RETRY_CYCLES)+1) bits wide.
- The retry counter is $clog2(MAX_RETRY+1) bits wide.
- Neither counter wraps.

## Timing
- Reset values: Busy=0, Data_Valid=0, Crc_Err=0, Nack_Err=0, Temp_Raw=0, Hum_Raw=0, I2c_Cmd_Valid=0, I2c_Cmd=4, I2c_Wr_Data=0. State is IDLE.
- Meas_Req sampled in cycle N gives Busy=1 and I2c_Cmd_Valid=1 in cycle N+1.
- The WAIT dwell is exactly WAIT_CYCLES cycles (RETRY_CYCLES after a retry), counted from the cycle after the STOP's Done to the cycle R_ADDR asserts Valid.
- Data_Valid, Crc_Err and any output update appear one cycle after the Done of the final STOP. Busy falls in the cycle after that.
- Nack_Err pulses one cycle after the error STOP's Done. Busy falls in the next cycle.
- I2c_Done and I2c_Cmd_Ready high in the same cycle: Done completes the current command; the next command is not presented until the following cycle.
- Reset asserted mid-sequence: all outputs return to reset values immediately and no STOP is issued; recovering the bus is the master's job. Latched Temp_Raw and Hum_Raw are cleared.

## Configuration
- SHT40_CRC_CHECK_EN defined:
  - The CRC logic is present.
  - Crc_Err reports mismatches.
  - The outputs update only when both CRCs are good.
- Not defined:
  - No CRC logic.
  - Crc_Err is tied to 0.
  - Temp_Raw and Hum_Raw update on every CHECK.
  - The CRC bytes are still read and discarded.

## Test plan
- Meas_Req with an ideal master, all ACK, read bytes BE EF 92 66 66 93 → command sequence 0:0x88, 1:0xFD, 4, WAIT_CYCLES idle cycles, 0:0x89, 2×5, 3, 4 → Data_Valid=1, Crc_Err=0, Temp_Raw=0xBEEF, Hum_Raw=0x6666.
- Same sequence with T_crc=0x00 (EN defined) → Data_Valid=1, Crc_Err=1, Temp_Raw and Hum_Raw unchanged from the previous pass. With EN undefined → Crc_Err=0 and Temp_Raw=0xBEEF.
- Master NACKs 0x88 → cmd 4, then a Nack_Err pulse, Busy=0, and no further command issued.
- Master NACKs 0x89 twice, then ACKs (MAX_RETRY=3) → two extra STOP+RETRY_CYCLES waits, then normal completion with Data_Valid=1.
- Master NACKs 0x89 four times → exactly 3 retries, then a Nack_Err pulse. A Meas_Req pulsed during Busy is ignored, so the command count is unchanged.
- rst_n low during R_BYTE index 3 → all outputs at reset values in the same cycle; after release, a fresh Meas_Req runs a full good sequence.

Source files
------------

// File: rtl/sht40_measure_ctrl.sv
// SHT40 measurement sequencer: drives a byte-level I2C master through
// command write, conversion wait, 6-byte readback and CRC check.
// Optional feature macro: SHT40_CRC_CHECK_EN (enables CRC-8 checking of the
// temperature and humidity words; without it the CRC bytes are read and dropped).
module sht40_measure_ctrl #(
    parameter logic [6:0]  DEV_ADDR     = 7'h44,
    parameter logic [7:0]  MEAS_CMD     = 8'hFD,
    parameter int unsigned WAIT_CYCLES  = 500000,
    parameter int unsigned RETRY_CYCLES = 50000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Meas_Req,
    output logic        Busy,
    output logic        Data_Valid,
    output logic        Crc_Err,
    output logic        Nack_Err,
    output logic [15:0] Temp_Raw,
    output logic [15:0] Hum_Raw,
    output logic        I2c_Cmd_Valid,
    input  logic        I2c_Cmd_Ready,
    output logic [2:0]  I2c_Cmd,
    output logic [7:0]  I2c_Wr_Data,
    input  logic        I2c_Done,
    input  logic        I2c_Nack,
    input  logic [7:0]  I2c_Rd_Data
);
    localparam int unsigned MAX_DWELL = (WAIT_CYCLES > RETRY_CYCLES) ? WAIT_CYCLES : RETRY_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_DWELL + 1);
    localparam int unsigned RTY_W     = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] CMD_START_WR = 3'd0;
    localparam logic [2:0] CMD_WR       = 3'd1;
    localparam logic [2:0] CMD_RD_ACK   = 3'd2;
    localparam logic [2:0] CMD_RD_NACK  = 3'd3;
    localparam logic [2:0] CMD_STOP     = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_W_ADDR, S_W_CMD, S_W_STOP, S_WAIT, S_R_ADDR, S_R_RETRY,
        S_R_BYTE, S_R_STOP, S_CHECK, S_ERR_STOP, S_ERR_STOP_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [2:0]         idx_q, idx_d;
    logic [47:0]        rd_buf_q, rd_buf_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               data_valid_q, data_valid_d;
    logic               crc_err_q, crc_err_d;
    logic               nack_err_q, nack_err_d;
    logic [15:0]        temp_q, temp_d;
    logic [15:0]        hum_q, hum_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               done_c;
    logic [47:0]        final_buf_c;

    // A Done only counts while a command is accepted and outstanding
    assign done_c      = pend_q && I2c_Done;
    assign final_buf_c = rd_buf_q;

`ifdef SHT40_CRC_CHECK_EN
    logic crc_bad_c;

    // CRC-8, poly 0x31, init 0xFF, MSB first, no reflection or final XOR
    function automatic logic [7:0] crc8_word(input logic [15:0] word);
        logic [7:0] crc;
        crc = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (crc[7] ^ word[i]) crc = {crc[6:0], 1'b0} ^ 8'h31;
            else                  crc = {crc[6:0], 1'b0};
        end
        return crc;
    endfunction

    // Buffer layout: T_hi T_lo T_crc H_hi H_lo H_crc
    assign crc_bad_c = (crc8_word(final_buf_c[47:32]) != final_buf_c[31:24]) ||
                       (crc8_word(final_buf_c[23:8])  != final_buf_c[7:0]);
`else
    logic unused_crc_c;
    assign unused_crc_c = ^{final_buf_c[31:24], final_buf_c[7:0]};
`endif

    // Next-state, command issue and output update logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        idx_d        = idx_q;
        rd_buf_d     = rd_buf_q;
        pend_d       = pend_q;
        busy_d       = busy_q;
        data_valid_d = 1'b0;
        crc_err_d    = crc_err_q;
        nack_err_d   = 1'b0;
        temp_d       = temp_q;
        hum_d        = hum_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_d        = cmd_q;
        wr_data_d    = wr_data_q;

        if (cmd_valid_q && I2c_Cmd_Ready) begin
            cmd_valid_d = 1'b0;
            pend_d      = 1'b1;
        end
        if (done_c) pend_d = 1'b0;

        case (state_q)
            S_IDLE: if (Meas_Req) begin
                busy_d      = 1'b1;
                retry_d     = '0;
                state_d     = S_W_ADDR;
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_START_WR;
                wr_data_d   = {DEV_ADDR, 1'b0};
            end
            S_W_ADDR: if (done_c) begin
                cmd_valid_d = 1'b1;
                if (I2c_Nack) begin
                    state_d = S_ERR_STOP;
                    cmd_d   = CMD_STOP;
                end else begin
                    state_d   = S_W_CMD;
                    cmd_d     = CMD_WR;
                    wr_data_d = MEAS_CMD;
                end
            end
            S_W_CMD: if (done_c) begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_STOP;
                state_d     = I2c_Nack ? S_ERR_STOP : S_W_STOP;
            end
            S_W_STOP: if (done_c) begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_R_ADDR;
                    cmd_valid_d = 1'b1;
                    cmd_d       = CMD_START_WR;
                    wr_data_d   = {DEV_ADDR, 1'b1};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_R_ADDR: if (done_c) begin
                cmd_valid_d = 1'b1;
                if (I2c_Nack) begin
                    state_d = S_R_RETRY;
                    cmd_d   = CMD_STOP;
                end else begin
                    idx_d   = '0;
                    state_d = S_R_BYTE;
                    cmd_d   = CMD_RD_ACK;
                end
            end
            S_R_RETRY: if (done_c) begin
                if (retry_q < RTY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RTY_W'(1);
                    cnt_d   = CNT_W'(RETRY_CYCLES - 1);
                    state_d = S_WAIT;
                end else begin
                    nack_err_d = 1'b1;
                    state_d    = S_ERR_STOP_DONE;
                end
            end
            S_R_BYTE: if (done_c) begin
                rd_buf_d    = {rd_buf_q[39:0], I2c_Rd_Data};
                cmd_valid_d = 1'b1;
                if (idx_q == 3'd5) begin
                    state_d = S_R_STOP;
                    cmd_d   = CMD_STOP;
                end else begin
                    idx_d = idx_q + 3'd1;
                    cmd_d = (idx_q == 3'd4) ? CMD_RD_NACK : CMD_RD_ACK;
                end
            end
            S_R_STOP: if (done_c) begin
                data_valid_d = 1'b1;
                state_d      = S_CHECK;
`ifdef SHT40_CRC_CHECK_EN
                crc_err_d = crc_bad_c;
                if (!crc_bad_c) begin
                    temp_d = final_buf_c[47:32];
                    hum_d  = final_buf_c[23:8];
                end
`else
                crc_err_d = 1'b0;
                temp_d    = final_buf_c[47:32];
                hum_d     = final_buf_c[23:8];
`endif
            end
            S_CHECK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR_STOP: if (done_c) begin
                nack_err_d = 1'b1;
                state_d    = S_ERR_STOP_DONE;
            end
            S_ERR_STOP_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            idx_q        <= '0;
            rd_buf_q     <= '0;
            pend_q       <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            nack_err_q   <= 1'b0;
            temp_q       <= '0;
            hum_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= CMD_STOP;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            idx_q        <= idx_d;
            rd_buf_q     <= rd_buf_d;
            pend_q       <= pend_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
            crc_err_q    <= crc_err_d;
            nack_err_q   <= nack_err_d;
            temp_q       <= temp_d;
            hum_q        <= hum_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign Busy          = busy_q;
    assign Data_Valid    = data_valid_q;
    assign Crc_Err       = crc_err_q;
    assign Nack_Err      = nack_err_q;
    assign Temp_Raw      = temp_q;
    assign Hum_Raw       = hum_q;
    assign I2c_Cmd_Valid = cmd_valid_q;
    assign I2c_Cmd       = cmd_q;
    assign I2c_Wr_Data   = wr_data_q;

endmodule

// File: tb/tb_sht40_measure_ctrl.sv
// Directed bench for sht40_measure_ctrl with a behavioural I2C master and
// scoreboards for issued commands and measurement results.
module tb_sht40_measure_ctrl;
    localparam int unsigned WAIT_CYC  = 20;
    localparam int unsigned RETRY_CYC = 8;
    localparam int unsigned MAX_RTY   = 3;

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] data;
        int         gap;
    } exp_cmd_t;

    typedef struct {
        logic        nack;
        logic        crc_err;
        logic [15:0] t;
        logic [15:0] h;
    } exp_res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_req;
    logic        busy, data_valid, crc_err, nack_err;
    logic [15:0] temp_raw, hum_raw;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd;
    logic [7:0]  wr_data;
    logic        done, nack;
    logic [7:0]  rd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int cmd_seen = 0;

    logic        nack_88;
    int          nack_89_left;
    logic [7:0]  rd_bytes [6];
    int          rd_idx;
    logic [15:0] cur_t, cur_h;

    exp_cmd_t exp_cmds[$];
    exp_res_t exp_res[$];

    sht40_measure_ctrl #(
        .DEV_ADDR(7'h44), .MEAS_CMD(8'hFD), .WAIT_CYCLES(WAIT_CYC),
        .RETRY_CYCLES(RETRY_CYC), .MAX_RETRY(MAX_RTY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Meas_Req(meas_req), .Busy(busy),
        .Data_Valid(data_valid), .Crc_Err(crc_err), .Nack_Err(nack_err),
        .Temp_Raw(temp_raw), .Hum_Raw(hum_raw), .I2c_Cmd_Valid(cmd_valid),
        .I2c_Cmd_Ready(cmd_ready), .I2c_Cmd(cmd), .I2c_Wr_Data(wr_data),
        .I2c_Done(done), .I2c_Nack(nack), .I2c_Rd_Data(rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [15:0] w);
        logic [7:0] c;
        c = 8'hFF;
        for (int b = 0; b < 2; b++) begin
            c = c ^ ((b == 0) ? w[15:8] : w[7:0]);
            for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic push_cmd(input logic [2:0] c, input logic [7:0] d, input int gap);
        exp_cmd_t e;
        e.cmd = c; e.data = d; e.gap = gap;
        exp_cmds.push_back(e);
    endtask

    task automatic push_write_phase();
        push_cmd(3'd0, 8'h88, 0);
        push_cmd(3'd1, 8'hFD, 1);
        push_cmd(3'd4, 8'h00, 1);
    endtask

    task automatic push_retry(input int gap);
        push_cmd(3'd0, 8'h89, gap);
        push_cmd(3'd4, 8'h00, 1);
    endtask

    task automatic push_read_phase(input int first_gap);
        push_cmd(3'd0, 8'h89, first_gap);
        for (int i = 0; i < 5; i++) push_cmd(3'd2, 8'h00, 1);
        push_cmd(3'd3, 8'h00, 1);
        push_cmd(3'd4, 8'h00, 1);
    endtask

    task automatic push_read_result(input logic [15:0] t, input logic [7:0] tc,
                                    input logic [15:0] h, input logic [7:0] hc);
        exp_res_t r;
        rd_bytes[0] = t[15:8]; rd_bytes[1] = t[7:0]; rd_bytes[2] = tc;
        rd_bytes[3] = h[15:8]; rd_bytes[4] = h[7:0]; rd_bytes[5] = hc;
`ifdef SHT40_CRC_CHECK_EN
        r.crc_err = (crc8(t) != tc) || (crc8(h) != hc);
        if (!r.crc_err) begin cur_t = t; cur_h = h; end
`else
        r.crc_err = 1'b0;
        cur_t = t; cur_h = h;
`endif
        r.nack = 1'b0; r.t = cur_t; r.h = cur_h;
        exp_res.push_back(r);
    endtask

    task automatic push_nack_result();
        exp_res_t r;
        r.nack = 1'b1; r.crc_err = 1'b0; r.t = cur_t; r.h = cur_h;
        exp_res.push_back(r);
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 meas_req = 1'b1;
        @(posedge clk); #1 meas_req = 1'b0;
    endtask

    task automatic request();
        pulse_req();
        check("req_busy", 32'(busy), 32'd1);
        check("req_cmd_valid", 32'(cmd_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        check("cmds_left", 32'(exp_cmds.size()), 32'd0);
        check("results_left", 32'(exp_res.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_crc_err", 32'(crc_err), 32'd0);
        check("rst_nack_err", 32'(nack_err), 32'd0);
        check("rst_temp", 32'(temp_raw), 32'd0);
        check("rst_hum", 32'(hum_raw), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd4);
        check("rst_wr_data", 32'(wr_data), 32'd0);
    endtask

    // Behavioural I2C master: accepts after one cycle, completes two cycles later
    initial begin : i2c_master
        exp_cmd_t   e;
        logic [2:0] c;
        logic [7:0] d;
        int         gap;
        cmd_ready = 1'b0; done = 1'b0; nack = 1'b0; rd_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            done = 1'b0; nack = 1'b0;
            if (rst_n && cmd_valid) begin
                c = cmd; d = wr_data; gap = cyc - last_done_cyc;
                cmd_seen++;
                check("cmd_expected", 32'(exp_cmds.size() != 0), 32'd1);
                if (exp_cmds.size() != 0) begin
                    e = exp_cmds.pop_front();
                    check("cmd_code", 32'(c), 32'(e.cmd));
                    if (e.cmd <= 3'd1) check("cmd_wr_data", 32'(d), 32'(e.data));
                    if (e.gap != 0) check("cmd_gap", 32'(gap), 32'(e.gap));
                end
                cmd_ready = 1'b1;
                @(posedge clk); #1;
                cmd_ready = 1'b0;
                if (rst_n) check("valid_drop", 32'(cmd_valid), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                done = 1'b1;
                last_done_cyc = cyc;
                if (c == 3'd0 && d == 8'h88) begin
                    nack = nack_88;
                end else if (c == 3'd0 && d == 8'h89) begin
                    if (nack_89_left > 0) begin
                        nack = 1'b1;
                        nack_89_left--;
                    end else begin
                        rd_idx = 0;
                    end
                end else if ((c == 3'd2 || c == 3'd3) && rd_idx < 6) begin
                    rd_data = rd_bytes[rd_idx];
                    rd_idx++;
                end
            end
        end
    end

    // Result monitor: compares Data_Valid / Nack_Err pulses against the scoreboard
    initial begin : result_monitor
        exp_res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && (data_valid || nack_err)) begin
                check("result_expected", 32'(exp_res.size() != 0), 32'd1);
                if (exp_res.size() != 0) begin
                    r = exp_res.pop_front();
                    check("res_nack_err", 32'(nack_err), 32'(r.nack));
                    check("res_data_valid", 32'(data_valid), 32'(!r.nack));
                    if (!r.nack) check("res_crc_err", 32'(crc_err), 32'(r.crc_err));
                    check("res_temp", 32'(temp_raw), 32'(r.t));
                    check("res_hum", 32'(hum_raw), 32'(r.h));
                    check("res_latency", 32'(cyc - last_done_cyc), 32'd1);
                    check("res_busy_high", 32'(busy), 32'd1);
                end
                @(negedge clk);
                check("pulse_width", 32'(data_valid | nack_err), 32'd0);
                check("busy_fall", 32'(busy), 32'd0);
            end
        end
    end

    initial begin : stimulus
        int base;
        meas_req = 1'b0; nack_88 = 1'b0; nack_89_left = 0; rd_idx = 0;
        cur_t = 16'h0; cur_h = 16'h0;
        for (int i = 0; i < 6; i++) rd_bytes[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Good measurement, reference bytes
        push_write_phase();
        push_read_phase(WAIT_CYC + 1);
        push_read_result(16'hBEEF, 8'h92, 16'h6666, 8'h93);
        request();
        wait_idle(500);

        // Temperature CRC corrupted
        push_write_phase();
        push_read_phase(WAIT_CYC + 1);
        push_read_result(16'h1234, crc8(16'h1234) ^ 8'h5A, 16'hABCD, crc8(16'hABCD));
        request();
        wait_idle(500);

        // Write address NACKed
        nack_88 = 1'b1;
        push_cmd(3'd0, 8'h88, 0);
        push_cmd(3'd4, 8'h00, 1);
        push_nack_result();
        request();
        wait_idle(500);
        nack_88 = 1'b0;

        // Read address NACKed twice, then ACKed
        nack_89_left = 2;
        push_write_phase();
        push_retry(WAIT_CYC + 1);
        push_retry(RETRY_CYC + 1);
        push_read_phase(RETRY_CYC + 1);
        push_read_result(16'h6543, crc8(16'h6543), 16'h1A2B, crc8(16'h1A2B));
        request();
        wait_idle(800);

        // Read address NACKed four times; stray requests while busy
        nack_89_left = 4;
        push_write_phase();
        push_retry(WAIT_CYC + 1);
        for (int i = 0; i < 3; i++) push_retry(RETRY_CYC + 1);
        push_nack_result();
        base = cmd_seen;
        request();
        repeat (10) @(negedge clk);
        pulse_req();
        repeat (25) @(negedge clk);
        pulse_req();
        wait_idle(800);
        check("retry_cmd_count", 32'(cmd_seen - base), 32'd11);
        nack_89_left = 0;

        // Reset during read byte index 3
        push_write_phase();
        push_cmd(3'd0, 8'h89, WAIT_CYC + 1);
        for (int i = 0; i < 4; i++) push_cmd(3'd2, 8'h00, 1);
        push_read_result(16'h7777, crc8(16'h7777), 16'h8888, crc8(16'h8888));
        void'(exp_res.pop_back());
        base = cmd_seen;
        request();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_seen - base >= 8) break;
        end
        check("reach_byte3", 32'(cmd_seen - base), 32'd8);
        rst_n = 1'b0;
        #1 check_reset_outputs();
        cur_t = 16'h0; cur_h = 16'h0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_cmds_left", 32'(exp_cmds.size()), 32'd0);

        // Fresh good measurement after reset
        push_write_phase();
        push_read_phase(WAIT_CYC + 1);
        push_read_result(16'hC0DE, crc8(16'hC0DE), 16'h0F1E, crc8(16'h0F1E));
        request();
        wait_idle(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
